// File: rtl/adder_share_arb.sv
// Round-robin front end that time-shares one pipelined W-bit adder among NREQ requesters.
// Each requester may have one operation in flight. Results return in issue order, tagged with the requester id.
module adder_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int LAT  = 4,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] ina_bus,
    input  logic [NREQ*W-1:0] inb_bus,
    input  logic [NREQ-1:0]   cin_bus,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   busy,
    output logic              rsp_valid,
    output logic [IDW-1:0]    rsp_id,
    output logic [W-1:0]      rsp_sum,
    output logic              rsp_cout,
    output logic              idle
);

    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  ptr_nxt;
    logic [IDW-1:0]  win;
    logic            found;
    logic [NREQ-1:0] elig;
    logic [NREQ-1:0] retire_mask;
    logic [NREQ-1:0] grant_mask;

    logic [LAT:0]    vld;
    logic [IDW-1:0]  id_q  [0:LAT];
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            cin_q;
    logic [W:0]      sum_q [1:LAT];

    // A requester whose result is leaving the pipeline this cycle is free again at this edge
    always_comb begin
        retire_mask = '0;
        if (vld[LAT]) begin
            retire_mask[id_q[LAT]] = 1'b1;
        end
    end

    assign elig = req & ~(busy & ~retire_mask);

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && elig[(int'(ptr) + k) % NREQ]) begin
                found = 1'b1;
                win   = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        grant_mask = '0;
        if (found) begin
            grant_mask[win] = 1'b1;
        end
    end

    assign ptr_nxt = (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            gnt   <= '0;
            busy  <= '0;
            vld   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= 1'b0;
            for (int k = 0; k <= LAT; k++) begin
                id_q[k] <= '0;
            end
            for (int k = 1; k <= LAT; k++) begin
                sum_q[k] <= '0;
            end
        end else begin
            gnt  <= grant_mask;
            busy <= (busy & ~retire_mask) | grant_mask;
            if (found) begin
                ptr   <= ptr_nxt;
                a_q   <= ina_bus[int'(win)*W +: W];
                b_q   <= inb_bus[int'(win)*W +: W];
                cin_q <= cin_bus[win];
            end
            vld     <= {vld[LAT-1:0], found};
            id_q[0] <= win;
            for (int k = 1; k <= LAT; k++) begin
                id_q[k] <= id_q[k-1];
            end
            // Full-width add in the first stage; later stages only delay the result
            sum_q[1] <= {1'b0, a_q} + {1'b0, b_q} + {{W{1'b0}}, cin_q};
            for (int k = 2; k <= LAT; k++) begin
                sum_q[k] <= sum_q[k-1];
            end
        end
    end

    assign rsp_valid = vld[LAT];
    assign rsp_id    = vld[LAT] ? id_q[LAT] : '0;
    assign rsp_sum   = vld[LAT] ? sum_q[LAT][W-1:0] : '0;
    assign rsp_cout  = vld[LAT] & sum_q[LAT][W];
    assign idle      = ~|busy;

endmodule

// File: doc/adder_share_arb.md
# adder_share_arb

Round-robin scheduler that shares one LAT-stage pipelined N-bit full adder among NREQ requesters. Each requester presents operands under a req/gnt handshake. The block arbitrates one issue per cycle, tags each operation with its requester id, and returns the sum on a shared response bus. Each requester may have at most one operation in flight. The block sits between several datapath clients and a single adder resource, so the adder is not replicated per client.

## Interface
- NREQ, 4: number of requesters, 2..8.
- W, 8: operand and sum width.
- LAT, 4: adder pipeline depth in clock edges from issue to result, 1..8.
- IDW, derived: ceil(log2(NREQ)), minimum 1.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  NREQ  request per requester; held high until gnt.
- ina_bus  in  NREQ*W  operand A; requester i uses bits [i*W +: W].
- inb_bus  in  NREQ*W  operand B, same packing.
- cin_bus  in  NREQ  carry-in per requester.
- gnt  out  NREQ  one-hot, one-cycle pulse: operands of that requester were captured.
- busy  out  NREQ  requester has an operation in flight; its req is ignored.
- rsp_valid  out  1  one-cycle pulse: rsp_* fields are valid.
- rsp_id  out  IDW  index of the requester that owns the result.
- rsp_sum  out  W  result bits [W-1:0].
- rsp_cout  out  1  result carry-out.
- idle  out  1  high when no operation is in flight.

## Operation
- Eligible set: req[i] & ~busy[i].
- Round-robin pointer ptr, range 0..NREQ-1:
  - The winner is the first eligible index searching ptr, ptr+1, … (mod NREQ).
  - After a grant to index i, ptr becomes (i+1) mod NREQ.
  - With no grant, ptr holds.
- Issue at edge E, when the eligible set is non-empty:
  - Capture the winner's ina, inb and cin, plus its id, into pipeline stage 1.
  - Set gnt[winner] = 1 and busy[winner] = 1 for the following cycle; all other gnt bits are 0.
- Arithmetic: {rsp_cout, rsp_sum} = ina + inb + cin, computed at width W+1 with no truncation beyond the carry. It must be bit-exact for all operands.
- The pipeline carries valid, id and partial results through LAT register stages.
  - The partial-sum split is implementer's choice.
  - The pipeline never stalls and rsp has no back-pressure.
- Result: rsp_valid pulses for exactly one cycle with rsp_id, rsp_sum and rsp_cout. Between pulses, rsp_sum, rsp_cout and rsp_id are 0.
- busy[i] clears at the edge that ends the rsp_valid cycle for id i. Requester i may be granted again at that same edge if req[i] is high.
- idle = ~|busy.
- Reset, including mid-operation:
  - All in-flight operations are discarded and no rsp is produced for them.
  - ptr = 0; gnt, busy, rsp_valid, rsp_id, rsp_sum and rsp_cout = 0; idle = 1.
  - req is ignored while rst = 1.

## Timing
- Issue edge E0 → gnt high during cycle [E0, E0+1).
- rsp_valid high during cycle [E0+LAT, E0+LAT+1).
- The earliest re-grant to the same requester is at edge E0+LAT+1, so the per-requester period is LAT+1 cycles.
- Aggregate throughput is one issue per cycle. Results return in issue order.
- Simultaneous issue and retire for different ids in the same cycle is legal.
- Simultaneous retire of id i and a new req[i] at the retire edge: the new request is eligible at that edge.
- Deasserting req before gnt withdraws the request with no side effects.
- Operand changes while req is high and not yet granted are legal; the values at the grant edge are used.
- First rising edge with rst = 0 after reset: arbitration starts with ptr = 0.

## Test plan
- Single op: requester 2 issues 0x3C + 0x05 + cin 0 → gnt[2] for 1 cycle; LAT cycles after gnt, rsp_valid = 1, rsp_id = 2, rsp_sum = 0x41, rsp_cout = 0.
- Carry and overflow: 0xFF + 0x01 + 1 → rsp_sum = 0x01, rsp_cout = 1. Also 0xFF + 0xFF + 1 → rsp_sum = 0xFF, rsp_cout = 1.
- Full contention: all four req high from reset → grants on consecutive cycles in order 0, 1, 2, 3; results in the same order on consecutive cycles. Requester 0 is re-granted at edge LAT+1 after its first grant, and not earlier.
- Fairness: ptr = 2, req = 4'b1011 → grant order 3, 0, 1. Requester 2 is never granted while its req is low.
- Busy blocking: requester 1 holds req high after its gnt → no second gnt[1] until after its rsp_valid. A req[1] pulse during busy produces nothing.
- Reset mid-flight: issue three ops, assert rst for 1 cycle at LAT-1 after the first gnt → no rsp_valid follows. busy = 0, idle = 1, next grant starts from index 0.
